fetch_sequencer: RTL and testbench

//   Instruction-fetch controller for the 16-bit pipelined datapath. Owns the PC.

---
 rtl/fetch_sequencer.sv | 113 +++++++++++
 tb/tb_fetch_sequencer.sv | 134 +++++++++++++
 2 files changed

// File: rtl/fetch_sequencer.sv
// Instruction-fetch sequencer: owns the PC, loads IF/ID, and handles stall, redirect/squash and HALT_WORD.
// Optional FETCH_PERF_EN adds saturating fetch_count/stall_count ports.
module fetch_sequencer #(
  parameter logic [15:0] RESET_PC  = 16'h0000,
  parameter logic [15:0] HALT_WORD = 16'hEFFF,
  parameter logic [15:0] NOP_WORD  = 16'h0000,
  parameter logic [15:0] PC_STEP   = 16'd2
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [15:0] imem_addr,
  input  logic [15:0] imem_instr,
  input  logic        stall,
  input  logic        redirect,
  input  logic [15:0] redirect_pc,
  input  logic        resume,
  output logic [15:0] ifid_instr,
  output logic [15:0] ifid_pc_plus2,
  output logic        ifid_valid,
  output logic        halted
`ifdef FETCH_PERF_EN
  ,
  output logic [15:0] fetch_count,
  output logic [15:0] stall_count
`endif
);

  typedef enum logic {RUN, HALTED} state_t;

  typedef struct packed {
    logic [15:0] instr;
    logic [15:0] pc_plus2;
    logic        valid;
  } ifid_t;

  state_t      state, state_n;
  logic [15:0] pc, pc_n;
  ifid_t       ifid, ifid_n;
  logic        fetch_fire;
  logic        run_stall;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= RUN;
      pc            <= RESET_PC;
      ifid.instr    <= NOP_WORD;
      ifid.pc_plus2 <= 16'h0000;
      ifid.valid    <= 1'b0;
    end else begin
      state <= state_n;
      pc    <= pc_n;
      ifid  <= ifid_n;
    end
  end

  always_comb begin
    state_n    = state;
    pc_n       = pc;
    ifid_n     = ifid;
    fetch_fire = 1'b0;
    run_stall  = 1'b0;
    if (redirect) begin
      // Squash whatever was fetched on the wrong path; also cancels a halt.
      pc_n            = redirect_pc & 16'hFFFE;
      ifid_n.instr    = NOP_WORD;
      ifid_n.pc_plus2 = 16'h0000;
      ifid_n.valid    = 1'b0;
      state_n         = RUN;
    end else if (state == RUN) begin
      if (stall) begin
        run_stall = 1'b1;
      end else begin
        ifid_n.instr    = imem_instr;
        ifid_n.pc_plus2 = pc + PC_STEP;
        ifid_n.valid    = 1'b1;
        fetch_fire      = 1'b1;
        if (imem_instr == HALT_WORD) state_n = HALTED;
        else                         pc_n    = pc + PC_STEP;
      end
    end else if (!stall) begin
      // Halt word has left ID once stall drops; bubbles follow until resume.
      ifid_n.instr    = NOP_WORD;
      ifid_n.pc_plus2 = 16'h0000;
      ifid_n.valid    = 1'b0;
      if (resume) begin
        pc_n    = pc + PC_STEP;
        state_n = RUN;
      end
    end
  end

  assign imem_addr     = pc;
  assign ifid_instr    = ifid.instr;
  assign ifid_pc_plus2 = ifid.pc_plus2;
  assign ifid_valid    = ifid.valid;
  assign halted        = (state == HALTED);

`ifdef FETCH_PERF_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_count <= 16'h0000;
      stall_count <= 16'h0000;
    end else begin
      if (fetch_fire && fetch_count != 16'hFFFF) fetch_count <= fetch_count + 16'd1;
      if (run_stall  && stall_count != 16'hFFFF) stall_count <= stall_count + 16'd1;
    end
  end
`else
  logic unused_perf;
  assign unused_perf = fetch_fire ^ run_stall;
`endif

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed table-driven bench for fetch_sequencer against a combinational ROM model.
module tb_fetch_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] imem_addr, imem_instr;
  logic        stall, redirect, resume;
  logic [15:0] redirect_pc;
  logic [15:0] ifid_instr, ifid_pc_plus2;
  logic        ifid_valid, halted;
`ifdef FETCH_PERF_EN
  logic [15:0] fetch_count, stall_count;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  // ROM: halt word at 0x0036, otherwise address XOR 0x1230.
  function automatic logic [15:0] rom(input logic [15:0] a);
    return (a == 16'h0036) ? 16'hEFFF : (a ^ 16'h1230);
  endfunction
  assign imem_instr = rom(imem_addr);

  fetch_sequencer dut (
    .clk(clk), .rst_n(rst_n), .imem_addr(imem_addr), .imem_instr(imem_instr),
    .stall(stall), .redirect(redirect), .redirect_pc(redirect_pc), .resume(resume),
    .ifid_instr(ifid_instr), .ifid_pc_plus2(ifid_pc_plus2), .ifid_valid(ifid_valid),
    .halted(halted)
`ifdef FETCH_PERF_EN
    , .fetch_count(fetch_count), .stall_count(stall_count)
`endif
  );

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        stall, redirect, resume;
    logic [15:0] rpc;
    logic [15:0] addr, instr, pc2;
    logic        chk_pc2, valid, halted;
  } vec_t;

  vec_t v[24];

  function automatic vec_t mk(input logic s, input logic r, input logic rs, input logic [15:0] rpc,
                              input logic [15:0] addr, input logic [15:0] instr, input logic [15:0] pc2,
                              input logic cp, input logic vl, input logic h);
    vec_t t;
    t.stall = s; t.redirect = r; t.resume = rs; t.rpc = rpc;
    t.addr = addr; t.instr = instr; t.pc2 = pc2; t.chk_pc2 = cp; t.valid = vl; t.halted = h;
    return t;
  endfunction

  initial begin
    //        stall red res rpc       addr      instr     pc2      cp vl h
    v[0]  = mk(0, 0, 0, 16'h0000, 16'h0002, 16'h1230, 16'h0002, 1, 1, 0);
    v[1]  = mk(0, 0, 0, 16'h0000, 16'h0004, 16'h1232, 16'h0004, 1, 1, 0);
    v[2]  = mk(0, 0, 0, 16'h0000, 16'h0006, 16'h1234, 16'h0006, 1, 1, 0);
    v[3]  = mk(0, 0, 0, 16'h0000, 16'h0008, 16'h1236, 16'h0008, 1, 1, 0);
    v[4]  = mk(1, 0, 0, 16'h0000, 16'h0008, 16'h1236, 16'h0008, 1, 1, 0);
    v[5]  = mk(1, 0, 0, 16'h0000, 16'h0008, 16'h1236, 16'h0008, 1, 1, 0);
    v[6]  = mk(0, 0, 0, 16'h0000, 16'h000A, 16'h1238, 16'h000A, 1, 1, 0);
    v[7]  = mk(1, 1, 0, 16'h0031, 16'h0030, 16'h0000, 16'h0000, 0, 0, 0);
    v[8]  = mk(0, 0, 0, 16'h0000, 16'h0032, 16'h1200, 16'h0032, 1, 1, 0);
    v[9]  = mk(0, 0, 0, 16'h0000, 16'h0034, 16'h1202, 16'h0034, 1, 1, 0);
    v[10] = mk(0, 0, 0, 16'h0000, 16'h0036, 16'h1204, 16'h0036, 1, 1, 0);
    v[11] = mk(0, 0, 0, 16'h0000, 16'h0036, 16'hEFFF, 16'h0038, 1, 1, 1);
    v[12] = mk(1, 0, 1, 16'h0000, 16'h0036, 16'hEFFF, 16'h0038, 1, 1, 1);
    v[13] = mk(0, 0, 0, 16'h0000, 16'h0036, 16'h0000, 16'h0000, 0, 0, 1);
    v[14] = mk(0, 0, 1, 16'h0000, 16'h0038, 16'h0000, 16'h0000, 0, 0, 0);
    v[15] = mk(0, 0, 0, 16'h0000, 16'h003A, 16'h1208, 16'h003A, 1, 1, 0);
    v[16] = mk(0, 0, 1, 16'h0000, 16'h003C, 16'h120A, 16'h003C, 1, 1, 0);
    v[17] = mk(0, 1, 0, 16'h0036, 16'h0036, 16'h0000, 16'h0000, 0, 0, 0);
    v[18] = mk(0, 0, 0, 16'h0000, 16'h0036, 16'hEFFF, 16'h0038, 1, 1, 1);
    v[19] = mk(0, 1, 0, 16'h0010, 16'h0010, 16'h0000, 16'h0000, 0, 0, 0);
    v[20] = mk(0, 0, 0, 16'h0000, 16'h0012, 16'h1220, 16'h0012, 1, 1, 0);
    v[21] = mk(0, 1, 0, 16'hFFFE, 16'hFFFE, 16'h0000, 16'h0000, 0, 0, 0);
    v[22] = mk(0, 0, 0, 16'h0000, 16'h0000, 16'hEDCE, 16'h0000, 1, 1, 0);
    v[23] = mk(0, 0, 0, 16'h0000, 16'h0002, 16'h1230, 16'h0002, 1, 1, 0);

    rst_n = 1'b0; stall = 1'b0; redirect = 1'b0; resume = 1'b0; redirect_pc = 16'h0000;
    @(negedge clk);
    chk("rst_addr",   imem_addr, 16'h0000);
    chk("rst_instr",  ifid_instr, 16'h0000);
    chk("rst_pc2",    ifid_pc_plus2, 16'h0000);
    chk("rst_valid",  {15'h0, ifid_valid}, 16'h0000);
    chk("rst_halted", {15'h0, halted}, 16'h0000);
    rst_n = 1'b1;

    for (int i = 0; i < 24; i++) begin
      stall = v[i].stall; redirect = v[i].redirect; resume = v[i].resume; redirect_pc = v[i].rpc;
      @(posedge clk); #1;
      chk($sformatf("v%0d_addr", i),  imem_addr, v[i].addr);
      chk($sformatf("v%0d_instr", i), ifid_instr, v[i].instr);
      if (v[i].chk_pc2) chk($sformatf("v%0d_pc2", i), ifid_pc_plus2, v[i].pc2);
      chk($sformatf("v%0d_valid", i),  {15'h0, ifid_valid}, {15'h0, v[i].valid});
      chk($sformatf("v%0d_halted", i), {15'h0, halted}, {15'h0, v[i].halted});
`ifdef FETCH_PERF_EN
      if (i == 2) chk("fetch_count_t1", fetch_count, 16'd3);
      if (i == 5) chk("stall_count_t2", stall_count, 16'd2);
`endif
    end

    // Drive into HALTED then assert reset between edges: outputs must clear immediately.
    stall = 1'b0; redirect = 1'b1; resume = 1'b0; redirect_pc = 16'h0036;
    @(posedge clk); #1;
    redirect = 1'b0;
    @(posedge clk); #1;
    chk("pre_rst_halted", {15'h0, halted}, 16'h0001);
    #2 rst_n = 1'b0;
    #1;
    chk("async_addr",   imem_addr, 16'h0000);
    chk("async_instr",  ifid_instr, 16'h0000);
    chk("async_pc2",    ifid_pc_plus2, 16'h0000);
    chk("async_valid",  {15'h0, ifid_valid}, 16'h0000);
    chk("async_halted", {15'h0, halted}, 16'h0000);
`ifdef FETCH_PERF_EN
    chk("async_fcount", fetch_count, 16'h0000);
    chk("async_scount", stall_count, 16'h0000);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_bad);
    $finish;
  end

endmodule
